counter_ctrl_fsm: RTL
=====================

# counter_ctrl_fsm

Control unit driving the 8-bit count-to-10 datapath (mux / A register / +1 adder / <10 comparator / output-port register). Sequences the datapath's `ASrcMuxSel`, `ALoad` and `OutPort` strobes from its `ALt10` status so the output port presents 0,1,…,9 once per pass. Adds run/stop control, a pass counter, a done pulse and status outputs. Sits beside the datapath inside the counter CPU top level.

## Interface
- `LOOPS`, default 1: passes per run; 0 means run until `stop`.
- `clk` in 1: clock, rising edge.
- `reset` in 1: reset, asynchronous, active-high.
- `start` in 1: level; sampled only in IDLE, launches a run.
- `stop` in 1: level; aborts any run and returns to IDLE.
- `step` in 1: single-step advance; port exists only with `CTRL_STEP_EN`.
- `ALt10` in 1: datapath status, A register < 10.
- `ASrcMuxSel` out 1: 0 selects constant 0, 1 selects adder result.
- `ALoad` out 1: A register load enable.
- `OutPort` out 1: output-port register load enable.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a run completes normally.
- `o_state` out 3: current state encoding.
- `o_pass_cnt` out 8: passes completed in the current run.
- `o_out_cnt` out 8: `OutPort` strobes issued since reset; wraps 255→0.

## Operation
- Moore FSM. Control outputs decode from the state register only, gated by `adv` (see Configuration).
- State encodings and outputs:
  - IDLE = 0: all strobes 0. Next state is INIT if `start`, else IDLE. Entering INIT from IDLE clears `o_pass_cnt`.
  - INIT = 1: `ASrcMuxSel=0`, `ALoad=1`. Next state CMP.
  - CMP = 2: strobes 0. Next state OUT if `ALt10`, else FIN.
  - OUT = 3: `OutPort=1`. `o_out_cnt` increments. Next state INC.
  - INC = 4: `ASrcMuxSel=1`, `ALoad=1`. Next state CMP.
  - FIN = 5: strobes 0. `o_pass_cnt` increments, saturating at 255. Next state INIT if `LOOPS==0` or the incremented count < `LOOPS`; else DONE.
  - DONE = 6: `done=1`. Next state IDLE.
  - Encoding 7 is illegal; next state is IDLE.
- `stop` has priority over all transitions: if `stop`=1 in any non-IDLE state, the next state is IDLE. No strobe is issued in that cycle, and `o_pass_cnt` holds its value.
- `start` and `stop` high together in IDLE: stay in IDLE.
- `start` outside IDLE is ignored. A `start` held high after DONE relaunches the run after one IDLE cycle.
- Transitions, counter updates and strobes occur only on `adv` cycles. On other cycles the state and counters hold.

## Timing
- Reset values: state IDLE; `o_pass_cnt=0`; `o_out_cnt=0`. All outputs are 0, including `busy` and `done`.
- Reset mid-run: immediate return to IDLE, with all strobes dropped asynchronously.
- `start` sampled at edge N: INIT occupies cycle N+1, so A=0 after edge N+2, and CMP in cycle N+2 sees a valid `ALt10`.
- One pass with `adv`≡1 takes 33 cycles: INIT 1 + 10×(CMP, OUT, INC) + final CMP 1 + FIN 1.
- `LOOPS=1`: `done` is high in the 34th cycle after the `start` edge, and IDLE follows on the 35th.
- The `OutPort` strobe in OUT loads the A value compared in the preceding CMP. The datapath port value updates one edge after the strobe.
- Output-port sequence per pass: 0,1,…,9. A ends at 10. The port holds 9 after the pass.

## Configuration
- `CTRL_STEP_EN` defined:
  - The `step` input exists.
  - In non-IDLE states, `adv = step`, so each `step` cycle executes exactly one state.
  - Strobes are asserted only in `step` cycles, so `ALoad` never repeats while holding.
  - IDLE responds to `start` regardless of `step`.
  - `stop` acts regardless of `step`.
- `CTRL_STEP_EN` undefined:
  - No `step` port.
  - `adv` is constant 1.

## Test plan
- Reset, then `start` pulse, `LOOPS=1`, with the datapath attached → port sequence 0..9. `o_out_cnt`=10, `o_pass_cnt`=1, `done` pulses once in cycle 34, `busy` is high for cycles 1–34.
- `LOOPS=3`, single `start` → 30 `OutPort` strobes, `o_pass_cnt`=3, exactly one `done`, and A is reset to 0 at the start of each pass.
- `LOOPS=0` with `stop` asserted after port=5 in the 2nd pass → IDLE the next cycle, no `done`, `o_pass_cnt`=1, no further strobes.
- `start`+`stop` together in IDLE → remains IDLE. `start` pulsed during the OUT state → no effect on the sequence.
- `reset` asserted during an INC cycle → outputs go to 0 immediately. After release, a new `start` produces a clean 0..9.
- `CTRL_STEP_EN`, `step` pulsed every 4th cycle → same 0..9 sequence with one state per `step`. No `ALoad` on non-step cycles, and A never skips a value.

Source files
------------

// File: rtl/counter_ctrl_fsm.sv
// Control FSM for the count-to-10 datapath: sequences mux/load/out strobes, run/stop, pass counting.
// Optional single-step mode enabled by defining CTRL_STEP_EN (adds the step input).
module counter_ctrl_fsm #(
    parameter int unsigned LOOPS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
`ifdef CTRL_STEP_EN
    input  logic       step,
`endif
    input  logic       ALt10,
    output logic       ASrcMuxSel,
    output logic       ALoad,
    output logic       OutPort,
    output logic       busy,
    output logic       done,
    output logic [2:0] o_state,
    output logic [7:0] o_pass_cnt,
    output logic [7:0] o_out_cnt
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned ST_W  = 3;

    typedef enum logic [ST_W-1:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        CMP     = 3'd2,
        OUT     = 3'd3,
        INC     = 3'd4,
        FIN     = 3'd5,
        DONE    = 3'd6,
        ILLEGAL = 3'd7
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_pass_cnt;
    logic [CNT_W-1:0]   r_out_cnt;
    logic [CNT_W-1:0]   w_pass_sat;
    logic               w_adv;
    logic               w_asrc;
    logic               w_aload;
    logic               w_outport;
    logic               w_done;
    logic               w_pass_clr;
    logic               w_pass_inc;
    logic               w_out_inc;

    // IDLE always listens to start; other states advance only on step when stepping is built in
`ifdef CTRL_STEP_EN
    assign w_adv = (r_state == IDLE) | step;
`else
    assign w_adv = 1'b1;
`endif

    assign w_pass_sat = (r_pass_cnt == {CNT_W{1'b1}}) ? r_pass_cnt : r_pass_cnt + CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and strobe decode; stop overrides everything outside IDLE
    always_comb begin
        w_next_state = r_state;
        w_asrc       = 1'b0;
        w_aload      = 1'b0;
        w_outport    = 1'b0;
        w_done       = 1'b0;
        w_pass_clr   = 1'b0;
        w_pass_inc   = 1'b0;
        w_out_inc    = 1'b0;
        if ((r_state != IDLE) && stop) begin
            w_next_state = IDLE;
        end else if (r_state == ILLEGAL) begin
            w_next_state = IDLE;
        end else if (w_adv) begin
            case (r_state)
                IDLE: begin
                    if (start && !stop) begin
                        w_next_state = INIT;
                        w_pass_clr   = 1'b1;
                    end
                end
                INIT: begin
                    w_aload      = 1'b1;
                    w_next_state = CMP;
                end
                CMP: begin
                    w_next_state = ALt10 ? OUT : FIN;
                end
                OUT: begin
                    w_outport    = 1'b1;
                    w_out_inc    = 1'b1;
                    w_next_state = INC;
                end
                INC: begin
                    w_asrc       = 1'b1;
                    w_aload      = 1'b1;
                    w_next_state = CMP;
                end
                FIN: begin
                    w_pass_inc = 1'b1;
                    if ((LOOPS == 32'd0) || (32'(w_pass_sat) < LOOPS)) begin
                        w_next_state = INIT;
                    end else begin
                        w_next_state = DONE;
                    end
                end
                DONE: begin
                    w_done       = 1'b1;
                    w_next_state = IDLE;
                end
                default: begin
                    w_next_state = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pass_cnt <= '0;
            r_out_cnt  <= '0;
        end else begin
            if (w_pass_clr) begin
                r_pass_cnt <= '0;
            end else if (w_pass_inc) begin
                r_pass_cnt <= w_pass_sat;
            end
            if (w_out_inc) begin
                r_out_cnt <= r_out_cnt + CNT_W'(1);
            end
        end
    end

    assign ASrcMuxSel = w_asrc;
    assign ALoad      = w_aload;
    assign OutPort    = w_outport;
    assign done       = w_done;
    assign busy       = (r_state != IDLE);
    assign o_state    = ST_W'(r_state);
    assign o_pass_cnt = r_pass_cnt;
    assign o_out_cnt  = r_out_cnt;

endmodule
